// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO status engine
package fifo_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = clog2(DEPTH_DEF);
    localparam int PTR_W      = ADDR_W_DEF + 1;

    // Bit positions inside the internal status bus
    localparam int FLAG_FULL    = 0;
    localparam int FLAG_EMPTY   = 1;
    localparam int FLAG_AFULL   = 2;
    localparam int FLAG_AEMPTY  = 3;
    localparam int FLAG_N       = 4;

endpackage

// File: rtl/fifo_ptr_fs.sv
// rtl/fifo_ptr_fs.sv - binary wrap-bit pointer with increment enable
module fifo_ptr_fs
    import fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_status_fs.sv
// rtl/fifo_status_fs.sv - FIFO pointer/flag engine; FIFO_STATUS_COUNT_EN adds a registered count port
module fifo_status_fs
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int AF_THRESH = 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk_fs,
    input  logic              rst_in_fs,
    input  logic              push_req_fs,
    input  logic              pop_req_fs,
    input  logic              err_clr_fs,
    output logic              wt_en_fs,
    output logic              rd_en_fs,
    output logic [ADDR_W-1:0] wt_addr_fs,
    output logic [ADDR_W-1:0] rd_addr_fs,
    output logic              full_fs,
    output logic              empty_fs,
    output logic              almost_full_fs,
    output logic              almost_empty_fs,
    output logic              push_on_full_error_fs,
    output logic              pop_on_empty_error_fs
`ifdef FIFO_STATUS_COUNT_EN
    ,
    output logic [ADDR_W:0]   count_fs
`endif
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     count;
    logic [FLAG_N-1:0] status;
    logic              push_err_q;
    logic              pop_err_q;

    // Requests are dropped outright while reset is held
    assign wt_en_fs = push_req_fs & ~status[FLAG_FULL]  & ~rst_in_fs;
    assign rd_en_fs = pop_req_fs  & ~status[FLAG_EMPTY] & ~rst_in_fs;

    fifo_ptr_fs #(.W(PW)) u_wptr (
        .clk (clk_fs),
        .rst (rst_in_fs),
        .inc (wt_en_fs),
        .ptr (wptr)
    );

    fifo_ptr_fs #(.W(PW)) u_rptr (
        .clk (clk_fs),
        .rst (rst_in_fs),
        .inc (rd_en_fs),
        .ptr (rptr)
    );

    assign count = wptr - rptr;

    // Full when the wrap bits differ but the addresses match
    assign status[FLAG_FULL]   = (wptr[PW-1] != rptr[PW-1]) &&
                                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign status[FLAG_EMPTY]  = (wptr == rptr);
    assign status[FLAG_AFULL]  = (count >= AF_LVL);
    assign status[FLAG_AEMPTY] = (count <= AE_LVL);

    assign full_fs         = status[FLAG_FULL];
    assign empty_fs        = status[FLAG_EMPTY];
    assign almost_full_fs  = status[FLAG_AFULL];
    assign almost_empty_fs = status[FLAG_AEMPTY];

    assign wt_addr_fs = wptr[ADDR_W-1:0];
    assign rd_addr_fs = rptr[ADDR_W-1:0];

    // A fresh error outranks a clear arriving in the same cycle
    always_ff @(posedge clk_fs) begin
        if (rst_in_fs) begin
            push_err_q <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            if (push_req_fs && status[FLAG_FULL]) begin
                push_err_q <= 1'b1;
            end else if (err_clr_fs) begin
                push_err_q <= 1'b0;
            end
            if (pop_req_fs && status[FLAG_EMPTY]) begin
                pop_err_q <= 1'b1;
            end else if (err_clr_fs) begin
                pop_err_q <= 1'b0;
            end
        end
    end

    assign push_on_full_error_fs = push_err_q;
    assign pop_on_empty_error_fs = pop_err_q;

`ifdef FIFO_STATUS_COUNT_EN
    logic [PW-1:0] count_q;

    always_ff @(posedge clk_fs) begin
        if (rst_in_fs) begin
            count_q <= '0;
        end else begin
            case ({wt_en_fs, rd_en_fs})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_fs = count_q;
`endif

endmodule

// File: tb/tb_fifo_status_fs.sv
// tb/tb_fifo_status_fs.sv - self-checking bench for fifo_status_fs
module tb_fifo_status_fs;

    logic       clk_fs = 1'b0;
    logic       rst_in_fs = 1'b1;
    logic       push_req_fs = 1'b0;
    logic       pop_req_fs = 1'b0;
    logic       err_clr_fs = 1'b0;
    logic       wt_en_fs;
    logic       rd_en_fs;
    logic [3:0] wt_addr_fs;
    logic [3:0] rd_addr_fs;
    logic       full_fs;
    logic       empty_fs;
    logic       almost_full_fs;
    logic       almost_empty_fs;
    logic       push_on_full_error_fs;
    logic       pop_on_empty_error_fs;
`ifdef FIFO_STATUS_COUNT_EN
    logic [4:0] count_fs;
`endif

    int checks = 0;
    int failures = 0;

    // Occupancy-level model of the FIFO
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    bit m_pfe = 0;
    bit m_poe = 0;

    fifo_status_fs dut (
        .clk_fs                (clk_fs),
        .rst_in_fs             (rst_in_fs),
        .push_req_fs           (push_req_fs),
        .pop_req_fs            (pop_req_fs),
        .err_clr_fs            (err_clr_fs),
        .wt_en_fs              (wt_en_fs),
        .rd_en_fs              (rd_en_fs),
        .wt_addr_fs            (wt_addr_fs),
        .rd_addr_fs            (rd_addr_fs),
        .full_fs               (full_fs),
        .empty_fs              (empty_fs),
        .almost_full_fs        (almost_full_fs),
        .almost_empty_fs       (almost_empty_fs),
        .push_on_full_error_fs (push_on_full_error_fs),
        .pop_on_empty_error_fs (pop_on_empty_error_fs)
`ifdef FIFO_STATUS_COUNT_EN
        ,
        .count_fs              (count_fs)
`endif
    );

    always #5 clk_fs = ~clk_fs;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_fs) begin
        bit acc_w;
        bit acc_r;
        if (rst_in_fs) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_pfe = 0; m_poe = 0;
        end else begin
            acc_w = push_req_fs && (m_cnt < 16);
            acc_r = pop_req_fs && (m_cnt > 0);
            if (push_req_fs && m_cnt == 16) m_pfe = 1;
            else if (err_clr_fs)            m_pfe = 0;
            if (pop_req_fs && m_cnt == 0)   m_poe = 1;
            else if (err_clr_fs)            m_poe = 0;
            m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
            m_wp  = (m_wp + int'(acc_w)) % 32;
            m_rp  = (m_rp + int'(acc_r)) % 32;
        end
    end

    always @(negedge clk_fs) begin
        chk("m_wt_en",   int'(wt_en_fs), int'(push_req_fs && !rst_in_fs && m_cnt < 16));
        chk("m_rd_en",   int'(rd_en_fs), int'(pop_req_fs && !rst_in_fs && m_cnt > 0));
        chk("m_wt_addr", int'(wt_addr_fs), m_wp % 16);
        chk("m_rd_addr", int'(rd_addr_fs), m_rp % 16);
        chk("m_full",    int'(full_fs), int'(m_cnt == 16));
        chk("m_empty",   int'(empty_fs), int'(m_cnt == 0));
        chk("m_afull",   int'(almost_full_fs), int'(m_cnt >= 14));
        chk("m_aempty",  int'(almost_empty_fs), int'(m_cnt <= 2));
        chk("m_pfe",     int'(push_on_full_error_fs), int'(m_pfe));
        chk("m_poe",     int'(pop_on_empty_error_fs), int'(m_poe));
`ifdef FIFO_STATUS_COUNT_EN
        chk("m_count",   int'(count_fs), m_cnt);
`endif
    end

    task automatic drive(input bit p, input bit q, input bit c);
        push_req_fs = p;
        pop_req_fs  = q;
        err_clr_fs  = c;
        @(posedge clk_fs);
        #2;
    endtask

    initial begin
        // Reset with requests asserted: they must be dropped
        rst_in_fs = 1'b1;
        drive(1, 1, 0);
        drive(1, 1, 0);
        chk("rst_wt_en", int'(wt_en_fs), 0);
        chk("rst_rd_en", int'(rd_en_fs), 0);
        rst_in_fs = 1'b0;
        drive(0, 0, 0);
        chk("rst_empty", int'(empty_fs), 1);
        chk("rst_aempty", int'(almost_empty_fs), 1);
        chk("rst_full", int'(full_fs), 0);
        chk("rst_errs", int'({push_on_full_error_fs, pop_on_empty_error_fs}), 0);
        chk("rst_addrs", int'({wt_addr_fs, rd_addr_fs}), 0);

        // Fill
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 0);
            if (i == 13) chk("fill13_afull", int'(almost_full_fs), 0);
            if (i == 14) chk("fill14_afull", int'(almost_full_fs), 1);
            if (i == 15) chk("fill15_full", int'(full_fs), 0);
        end
        chk("fill_full", int'(full_fs), 1);
        chk("fill_wt_addr", int'(wt_addr_fs), 0);

        // Overflow, hold, clear racing a new error, plain clear
        drive(1, 0, 0);
        chk("ovf_err", int'(push_on_full_error_fs), 1);
        drive(0, 0, 0);
        chk("ovf_hold", int'(push_on_full_error_fs), 1);
        drive(1, 0, 1);
        chk("ovf_clr_race", int'(push_on_full_error_fs), 1);
        drive(0, 0, 1);
        chk("ovf_clr", int'(push_on_full_error_fs), 0);

        // Drain and underflow
        for (int i = 0; i < 16; i++) drive(0, 1, 0);
        chk("drain_empty", int'(empty_fs), 1);
        chk("drain_rd_addr", int'(rd_addr_fs), 0);
        drive(0, 1, 0);
        chk("udf_err", int'(pop_on_empty_error_fs), 1);
        chk("udf_rd_addr", int'(rd_addr_fs), 0);

        // Push+pop while empty: push wins, error re-asserted
        drive(0, 0, 1);
        chk("udf_clr", int'(pop_on_empty_error_fs), 0);
        drive(1, 1, 0);
        chk("pp_empty_err", int'(pop_on_empty_error_fs), 1);
        chk("pp_empty_cnt", int'(empty_fs), 0);
        drive(0, 0, 1);

        // Reach count 5, then 40 cycles of push+pop
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 1, 0);
        chk("sim_wt_addr", int'(wt_addr_fs), 13);
        chk("sim_rd_addr", int'(rd_addr_fs), 8);
        chk("sim_flags", int'({full_fs, empty_fs, almost_full_fs, almost_empty_fs}), 0);

        // Refill to full after the wrap, then push+pop while full
        for (int i = 0; i < 11; i++) drive(1, 0, 0);
        chk("wrap_full", int'(full_fs), 1);
        chk("wrap_addrs", int'({wt_addr_fs, rd_addr_fs}), 8'h88);
        drive(1, 1, 0);
        chk("ppf_full", int'(full_fs), 0);
        chk("ppf_afull", int'(almost_full_fs), 1);
        chk("ppf_err", int'(push_on_full_error_fs), 1);
        chk("ppf_rd_addr", int'(rd_addr_fs), 9);

        // Down to 9 entries, then reset mid-stream
        for (int i = 0; i < 6; i++) drive(0, 1, 0);
        chk("pre_rst_empty", int'(empty_fs), 0);
        rst_in_fs = 1'b1;
        drive(1, 1, 0);
        chk("mid_rst_empty", int'(empty_fs), 1);
        chk("mid_rst_errs", int'({push_on_full_error_fs, pop_on_empty_error_fs}), 0);
        chk("mid_rst_addrs", int'({wt_addr_fs, rd_addr_fs}), 0);
        rst_in_fs = 1'b0;
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
